// File: rtl/sysid_uptime_regs_if.sv
// Avalon-MM slave bus bundle for the system-ID / uptime register bank.
// There is no waitrequest: every read or write is accepted in the cycle it is presented.
interface sysid_uptime_regs_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_uptime_regs.sv
// System-ID register bank: build ID and timestamp, plus a prescaled uptime counter
// with freeze/clear, a 64-bit snapshot read, a sticky overflow flag and two scratch words.
module sysid_uptime_regs #(
  parameter logic [31:0] ID_VALUE     = 32'hC10D_0391,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int          UPTIME_WIDTH = 48,
  parameter int          TICK_DIV     = 50
) (
  input  logic               clock,
  input  logic               reset,
  sysid_uptime_regs_if.slave bus
);

  localparam int PW = 16;

  logic [PW-1:0]           prescaler;
  logic [UPTIME_WIDTH-1:0] uptime;
  logic [31:0]             shadow_hi;
  logic [31:0]             scratch0;
  logic [31:0]             scratch1;
  logic                    freeze;
  logic                    ovf;

  logic        tick;
  logic        clr;
  logic        wrap;
  logic        ctrl_wr;
  logic        status_w1c;
  logic [31:0] uptime_hi_ext;
  logic [31:0] rd_mux;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    return r;
  endfunction

  assign tick          = !freeze && (prescaler == PW'(TICK_DIV - 1));
  assign ctrl_wr       = bus.write && (bus.address == 3'd4) && bus.byteenable[0];
  assign clr           = ctrl_wr && bus.writedata[1];
  assign status_w1c    = bus.write && (bus.address == 3'd5) && bus.byteenable[0] && bus.writedata[0];
  // A clear swallows the tick, so an overflow cannot be flagged on a clearing edge.
  assign wrap          = tick && (&uptime) && !clr;
  assign uptime_hi_ext = 32'(uptime[UPTIME_WIDTH-1:32]);

  always_comb begin
    rd_mux = 32'd0;
    case (bus.address)
      3'd0: rd_mux = ID_VALUE;
      3'd1: rd_mux = TIMESTAMP;
      3'd2: rd_mux = uptime[31:0];
      3'd3: rd_mux = shadow_hi;
      3'd4: rd_mux = {31'd0, freeze};
      3'd5: rd_mux = {31'd0, ovf};
      3'd6: rd_mux = scratch0;
      3'd7: rd_mux = scratch1;
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      uptime    <= '0;
    end else if (clr) begin
      prescaler <= '0;
      uptime    <= '0;
    end else if (tick) begin
      prescaler <= '0;
      uptime    <= uptime + UPTIME_WIDTH'(1);
    end else if (!freeze) begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Overflow set beats a same-edge write-1-to-clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      freeze   <= 1'b0;
      ovf      <= 1'b0;
      scratch0 <= '0;
      scratch1 <= '0;
    end else begin
      if (ctrl_wr) freeze <= bus.writedata[0];
      if (wrap)            ovf <= 1'b1;
      else if (status_w1c) ovf <= 1'b0;
      if (bus.write && bus.address == 3'd6)
        scratch0 <= merge_bytes(scratch0, bus.writedata, bus.byteenable);
      if (bus.write && bus.address == 3'd7)
        scratch1 <= merge_bytes(scratch1, bus.writedata, bus.byteenable);
    end
  end

  // Read path samples pre-edge state, so a coincident write is not visible in the data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.readdata      <= '0;
      bus.readdatavalid <= 1'b0;
      shadow_hi         <= '0;
    end else begin
      bus.readdatavalid <= bus.read;
      if (bus.read) bus.readdata <= rd_mux;
      if (bus.read && bus.address == 3'd2) shadow_hi <= uptime_hi_ext;
    end
  end

endmodule

// File: tb/tb_sysid_uptime_regs.sv
// Scoreboard bench for sysid_uptime_regs: reads push expected data computed from a
// tick-count reference model; a monitor pops and compares on every readdatavalid.
module tb_sysid_uptime_regs;
  localparam int          W    = 48;
  localparam int          DIV  = 4;
  localparam logic [31:0] IDV  = 32'hC10D_0391;
  localparam logic [31:0] TSV  = 32'h0000_0000;
  localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sysid_uptime_regs_if bus ();

  sysid_uptime_regs #(
    .ID_VALUE(IDV), .TIMESTAMP(TSV), .UPTIME_WIDTH(W), .TICK_DIV(DIV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [2:0]  a;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: uptime = total ticks = m_up + (unfrozen cycles since anchor)/DIV.
  longint unsigned m_up, m_cyc;
  bit          m_freeze, m_ovf;
  logic [31:0] m_shadow;
  logic [31:0] m_scr[2];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_up = 0; m_cyc = 0; m_freeze = 0; m_ovf = 0; m_shadow = 0;
    m_scr[0] = 0; m_scr[1] = 0;
  endfunction

  function automatic longint unsigned up_now();
    return (m_up + m_cyc / DIV) & MASK;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return IDV;
      3'd1: return TSV;
      3'd2: return up_now() & 64'hFFFF_FFFF;
      3'd3: return m_shadow;
      3'd4: return {31'd0, m_freeze};
      3'd5: return {31'd0, m_ovf};
      3'd6: return m_scr[0];
      default: return m_scr[1];
    endcase
  endfunction

  function automatic void model_edge(input bit rd, input bit wr, input logic [2:0] a,
                                     input logic [31:0] d, input logic [3:0] be);
    longint unsigned t0, t1, c1;
    bit wrapped;
    t0 = m_up + m_cyc / DIV;
    if (rd && a == 3'd2) m_shadow = 32'(up_now() >> 32);
    c1 = m_freeze ? m_cyc : m_cyc + 1;
    t1 = m_up + c1 / DIV;
    wrapped = (t1 >> W) != (t0 >> W);
    m_cyc = c1;
    if (wr) begin
      case (a)
        3'd4: if (be[0]) begin
          if (d[1]) begin m_up = 0; m_cyc = 0; wrapped = 0; end
          m_freeze = d[0];
        end
        3'd5: if (be[0] && d[0]) m_ovf = 0;
        3'd6, 3'd7: for (int i = 0; i < 4; i++)
          if (be[i]) m_scr[a[0]][8*i +: 8] = d[8*i +: 8];
        default: ;
      endcase
    end
    if (wrapped) m_ovf = 1;
  endfunction

  // Called just after a falling edge; returns at the next falling edge.
  task automatic cycle(input bit rd, input bit wr, input logic [2:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = d; bus.byteenable = be;
    if (rd) begin
      e.a = a; e.d = model_read(a);
      exp_q.push_back(e);
    end
    model_edge(rd, wr, a, d, be);
    @(negedge clock);
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    cycle(1'b1, 1'b0, a, 32'd0, 4'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    cycle(1'b0, 1'b1, a, d, be);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
  endtask

  // Preload counter state; the prescaler value counts cycles already spent towards the next tick.
  task automatic force_up(input logic [W-1:0] val, input logic [15:0] pre);
    force dut.uptime = val;
    force dut.prescaler = pre;
    #1;
    release dut.uptime;
    release dut.prescaler;
    m_up = val; m_cyc = pre;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (bus.readdatavalid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_rdv actual=1 expected=0");
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("rd_w%0d", e.a), bus.readdata, e.d);
      end
    end
  end

  initial begin
    bus.read = 0; bus.write = 0; bus.address = 0; bus.writedata = 0; bus.byteenable = 0;
    model_reset();
    #1;
    chk("reset_readdata", bus.readdata, 32'd0);
    chk("reset_rdv", {31'd0, bus.readdatavalid}, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    rd(3'd0); rd(3'd1); rd(3'd3);
    idle(37);
    rd(3'd2); rd(3'd3);

    // Snapshot: the high word must come from the earlier low-word read, not the live count.
    force_up(48'h1_FFFF_FFFF, 16'd0);
    rd(3'd2);
    idle(5);
    rd(3'd3);
    rd(3'd2);

    force_up({W{1'b1}}, 16'd3);
    idle(1);
    rd(3'd5); rd(3'd2);
    force_up({W{1'b1}}, 16'd3);
    wr(3'd5, 32'd1, 4'b0001);
    rd(3'd5);
    wr(3'd5, 32'd1, 4'b0001);
    rd(3'd5);

    wr(3'd4, 32'd1, 4'b0001);
    rd(3'd2);
    idle(100);
    rd(3'd2);
    wr(3'd4, 32'd2, 4'b0001);
    rd(3'd2); rd(3'd4);

    wr(3'd6, 32'hAABB_CCDD, 4'b1111);
    wr(3'd6, 32'h1122_3344, 4'b0101);
    rd(3'd6);
    wr(3'd7, 32'h5566_7788, 4'b1111);
    cycle(1'b1, 1'b1, 3'd7, 32'hDEAD_BEEF, 4'b1111);
    rd(3'd7);

    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
            $urandom, 4'($urandom_range(0, 15)));

    // Reset while a read result is on the bus and another read is being presented.
    wr(3'd7, 32'h0BAD_F00D, 4'b1111);
    bus.read = 1'b1; bus.address = 3'd7;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("async_rst_rdv", {31'd0, bus.readdatavalid}, 32'd0);
    chk("async_rst_readdata", bus.readdata, 32'd0);
    bus.read = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clock); @(negedge clock);
    chk("rst_held_rdv", {31'd0, bus.readdatavalid}, 32'd0);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) rd(3'(a));
    idle(2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_rdv actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_uptime_regs.md
Name: sysid_uptime_regs

Overview:
Parametrised system-identification register bank on the HPS lightweight Avalon-MM bus, successor to the fixed two-word system ID slave. It returns a build ID and build timestamp, and adds:
- a free-running uptime counter with prescaler, freeze and clear;
- an atomic 64-bit snapshot read;
- a sticky overflow flag;
- two byte-writable scratch registers.
Software uses it to confirm the loaded bitstream and to time events.

Parameters:
ID_VALUE, 32'hC10D_0391, system ID returned at word 0
TIMESTAMP, 32'h0000_0000, build timestamp returned at word 1
UPTIME_WIDTH, 48, uptime counter width, legal 33..64
TICK_DIV, 50, clocks per uptime increment, legal 1..65535

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
address  input  3  word address
read  input  1  Avalon read strobe
write  input  1  Avalon write strobe
writedata  input  32  write data
byteenable  input  4  byte lanes for write
readdata  output  32  registered read data
readdatavalid  output  1  high one cycle after an accepted read

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset values: readdata=0, readdatavalid=0, prescaler=0, uptime=0, shadow_hi=0, freeze=0, ovf=0, scratch0/1=0.
- No waitrequest. Every read/write is accepted in the cycle presented.
- Read latency is fixed at 1: readdata and readdatavalid update on the clock edge after read=1.
- readdatavalid=0 in all other cycles. readdata holds its last value.
- read and write asserted together: the write is performed, and the read returns the pre-write value.
- Register map (word address):
  - 0 ID (RO) = ID_VALUE.
  - 1 TIMESTAMP (RO) = TIMESTAMP.
  - 2 UPTIME_LO (RO) = uptime[31:0]. In the same edge, shadow_hi <= uptime[UPTIME_WIDTH-1:32], zero-extended to 32 bits.
  - 3 UPTIME_HI (RO) = shadow_hi. Reading it never updates the shadow.
  - 4 CTRL:
    - bit0 freeze (RW).
    - bit1 clear (WO, self-clearing; reads 0).
    - bits 31:2 read 0.
  - 5 STATUS: bit0 ovf, sticky, write-1-to-clear. Other bits read 0.
  - 6 SCRATCH0 (RW, byteenable honoured).
  - 7 SCRATCH1 (RW, byteenable honoured).
- Writes to RO words are ignored. CTRL and STATUS use writedata bit 0/1 only when byteenable[0]=1.
- Prescaler:
  - Counts 0..TICK_DIV-1 while freeze=0. Tick is asserted when prescaler==TICK_DIV-1, then the prescaler wraps to 0.
  - TICK_DIV=1 ticks every clock.
  - While freeze=1, the prescaler and uptime both hold.
- Uptime:
  - Increments by 1 on tick.
  - On a tick at the all-ones value, uptime wraps to 0 and ovf is set.
- CTRL clear write: uptime and prescaler go to 0 on that edge. Clear beats a coincident tick. ovf is unaffected.
- Same-edge set/clear of ovf (overflow tick plus W1C write): set wins, ovf=1.
- Write to CTRL with bit0=1 and bit1=1: clear is performed and freeze=1 afterwards.
- The UPTIME_LO read value and the shadow capture are the counter value before any same-edge increment or clear.
- Reset asserted mid-transfer clears readdatavalid immediately. No pending read survives reset.

Test Plan:
- Reset, then read words 0, 1 -> readdatavalid pulses one cycle after each read; readdata=32'hC10D_0391, then 32'h0000_0000. Read word 3 -> 0.
- TICK_DIV=4, run 40 clocks after reset release, read word 2 -> value 9 or 10, consistent with the issue cycle. A subsequent word-3 read returns 0.
- Force uptime to 0x0000_0001_FFFF_FFFF (UPTIME_WIDTH=48, TICK_DIV=1), read word 2 -> 0xFFFF_FFFF. Wait 5 clocks, read word 3 -> 0x0000_0001, the snapshot and not the live value.
- UPTIME_WIDTH=33, TICK_DIV=1, counter at all-ones:
  - After the next tick -> uptime=0 and STATUS=1.
  - Write STATUS=1 in the same cycle as the next wrap -> STATUS stays 1.
  - A later plain W1C -> STATUS=0.
- Write CTRL=1 (freeze) -> two UPTIME_LO reads 100 clocks apart match. Write CTRL=2 -> uptime reads 0. CTRL readback = 0.
- Write SCRATCH0=0xAABBCCDD, byteenable=4'b1111, then writedata=0x11223344 with byteenable=4'b0101 -> read 0xAA22CC44. Simultaneous read+write on SCRATCH1 returns the old value. Async reset mid-sequence -> all registers 0, readdatavalid=0 with no clock edge.
